ipsl_pcie_cfg_arb: RTL and testbench

IPSL_PCIE_CFG_ARB -- requirements
Module: ipsl_pcie_cfg_arb

---
 rtl/ipsl_pcie_cfg_pkg.sv | 26 ++
 rtl/ipsl_pcie_cfg_arb_if.sv | 44 ++++
 rtl/ipsl_pcie_cfg_arb_rr.sv | 17 +
 rtl/ipsl_pcie_cfg_arb.sv | 125 ++++++++++++
 tb/tb_ipsl_pcie_cfg_arb.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ipsl_pcie_cfg_pkg.sv
// Shared types and constants for the PCIe configuration-request arbiter.
// Holds FSM encodings, the success status code and default parameter values.
package ipsl_pcie_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic [2:0]  CPL_STATUS_SC      = 3'b000;
    localparam logic [15:0] TIMEOUT_CYCLES_DEF = 16'd4096;
    localparam logic [7:0]  TAG_INIT_DEF       = 8'h00;

    // One requester's TLP fields, in the order they are presented to the engine.
    typedef struct packed {
        logic        fmt;
        logic        typ;
        logic [3:0]  fbe;
        logic [15:0] des_id;
        logic [9:0]  reg_num;
        logic [31:0] wdata;
    } cfg_req_t;

endpackage

// File: rtl/ipsl_pcie_cfg_arb_if.sv
// Requester-side and transaction-engine-side signals of the config arbiter.
// req_valid[i] is held until req_ready[i]; fields are taken on that edge.
interface ipsl_pcie_cfg_arb_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_fmt;
    logic [1:0]  req_type;
    logic [7:0]  req_fbe;
    logic [31:0] req_des_id;
    logic [19:0] req_reg_num;
    logic [63:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [2:0]  rsp_status;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        pcie_cfg_fmt;
    logic        pcie_cfg_type;
    logic [7:0]  pcie_cfg_tag;
    logic [3:0]  pcie_cfg_fbe;
    logic [15:0] pcie_cfg_des_id;
    logic [9:0]  pcie_cfg_reg_num;
    logic [31:0] pcie_cfg_tx_data;
    logic        tx_en;
    logic        pcie_cfg_cpl_rcv;
    logic [2:0]  pcie_cfg_cpl_status;
    logic [31:0] pcie_cfg_rx_data;
    logic        stray_cpl;

    modport slave (
        input  req_valid, req_fmt, req_type, req_fbe, req_des_id, req_reg_num, req_wdata,
        input  pcie_cfg_cpl_rcv, pcie_cfg_cpl_status, pcie_cfg_rx_data,
        output req_ready, rsp_valid, rsp_status, rsp_rdata, rsp_timeout,
        output pcie_cfg_fmt, pcie_cfg_type, pcie_cfg_tag, pcie_cfg_fbe, pcie_cfg_des_id,
        output pcie_cfg_reg_num, pcie_cfg_tx_data, tx_en, stray_cpl
    );

    modport master (
        output req_valid, req_fmt, req_type, req_fbe, req_des_id, req_reg_num, req_wdata,
        output pcie_cfg_cpl_rcv, pcie_cfg_cpl_status, pcie_cfg_rx_data,
        input  req_ready, rsp_valid, rsp_status, rsp_rdata, rsp_timeout,
        input  pcie_cfg_fmt, pcie_cfg_type, pcie_cfg_tag, pcie_cfg_fbe, pcie_cfg_des_id,
        input  pcie_cfg_reg_num, pcie_cfg_tx_data, tx_en, stray_cpl
    );
endinterface

// File: rtl/ipsl_pcie_cfg_arb_rr.sv
// Two-way round-robin pick: a lone requester wins, on contention the one
// not granted last wins. last_grant_i = 1 means requester 1 won last time.
module ipsl_pcie_cfg_arb_rr (
    input  logic [1:0] req_valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);
    always_comb begin
        grant_o = 2'b00;
        case (req_valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end
endmodule

// File: rtl/ipsl_pcie_cfg_arb.sv
// Arbitrates two config-request sources onto one PCIe config transaction
// engine, one request outstanding at a time, with completion timeout.
module ipsl_pcie_cfg_arb
    import ipsl_pcie_cfg_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic [7:0]  TAG_INIT       = TAG_INIT_DEF
) (
    input  logic                      pclk_div2,
    input  logic                      apb_rst_n,
    input  logic                      arb_en,
    ipsl_pcie_cfg_arb_if.slave        bus,
    output arb_state_e                state_dbg_o
);
    arb_state_e  state_q, state_d;
    logic        last_q;
    logic [7:0]  tag_q;
    logic [15:0] cnt_q;
    logic [1:0]  grant_q;
    cfg_req_t    tlp_q;
    logic [2:0]  rsp_status_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_timeout_q;
    logic        stray_q;
    logic [1:0]  rr_grant;
    logic        take;
    logic        sel;
    cfg_req_t    req_sel;

    ipsl_pcie_cfg_arb_rr u_rr (
        .req_valid_i  (bus.req_valid),
        .last_grant_i (last_q),
        .grant_o      (rr_grant)
    );

    assign sel = rr_grant[1];

    always_comb begin
        req_sel.fmt     = bus.req_fmt[sel];
        req_sel.typ     = bus.req_type[sel];
        req_sel.fbe     = sel ? bus.req_fbe[7:4]        : bus.req_fbe[3:0];
        req_sel.des_id  = sel ? bus.req_des_id[31:16]   : bus.req_des_id[15:0];
        req_sel.reg_num = sel ? bus.req_reg_num[19:10]  : bus.req_reg_num[9:0];
        req_sel.wdata   = sel ? bus.req_wdata[63:32]    : bus.req_wdata[31:0];
    end

    // Nothing is accepted while reset is held, even though the FSM sits in IDLE.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (apb_rst_n && arb_en && (bus.req_valid != 2'b00)) begin
                    take    = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.pcie_cfg_cpl_rcv || (cnt_q == TIMEOUT_CYCLES - 16'd1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk_div2) begin
        if (!apb_rst_n) begin
            state_q       <= ST_IDLE;
            last_q        <= 1'b1;
            tag_q         <= TAG_INIT;
            cnt_q         <= '0;
            grant_q       <= '0;
            tlp_q         <= '0;
            rsp_status_q  <= CPL_STATUS_SC;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            stray_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            stray_q <= bus.pcie_cfg_cpl_rcv && (state_q != ST_WAIT);
            if (take) begin
                tlp_q   <= req_sel;
                grant_q <= rr_grant;
                last_q  <= rr_grant[1];
            end
            if (state_q == ST_ISSUE) begin
                tag_q <= tag_q + 8'd1;
                cnt_q <= '0;
            end else if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q + 16'd1;
            end
            // A completion arriving on the expiry cycle still counts as a completion.
            if ((state_q == ST_WAIT) && (state_d == ST_RESP)) begin
                if (bus.pcie_cfg_cpl_rcv) begin
                    rsp_status_q  <= bus.pcie_cfg_cpl_status;
                    rsp_rdata_q   <= bus.pcie_cfg_rx_data;
                    rsp_timeout_q <= 1'b0;
                end else begin
                    rsp_status_q  <= CPL_STATUS_SC;
                    rsp_rdata_q   <= '0;
                    rsp_timeout_q <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready        = take ? rr_grant : 2'b00;
    assign bus.tx_en            = (state_q == ST_ISSUE);
    assign bus.rsp_valid        = (state_q == ST_RESP) ? grant_q : 2'b00;
    assign bus.rsp_timeout      = (state_q == ST_RESP) && rsp_timeout_q;
    assign bus.rsp_status       = rsp_status_q;
    assign bus.rsp_rdata        = rsp_rdata_q;
    assign bus.pcie_cfg_fmt     = tlp_q.fmt;
    assign bus.pcie_cfg_type    = tlp_q.typ;
    assign bus.pcie_cfg_tag     = tag_q;
    assign bus.pcie_cfg_fbe     = tlp_q.fbe;
    assign bus.pcie_cfg_des_id  = tlp_q.des_id;
    assign bus.pcie_cfg_reg_num = tlp_q.reg_num;
    assign bus.pcie_cfg_tx_data = tlp_q.wdata;
    assign bus.stray_cpl        = stray_q;
    assign state_dbg_o          = state_q;
endmodule

// File: tb/tb_ipsl_pcie_cfg_arb.sv
// Bench for ipsl_pcie_cfg_arb: a cycle-level transaction model predicts
// grants, launches, responses and stray pulses; a monitor checks them.
module tb_ipsl_pcie_cfg_arb;
    import ipsl_pcie_cfg_pkg::*;

    localparam logic [15:0] TO    = 16'd16;
    localparam logic [7:0]  TAG0  = 8'h00;
    localparam int          TX_W  = 104;
    localparam int          RSP_W = 70;

    logic       pclk_div2 = 1'b0;
    logic       apb_rst_n = 1'b0;
    logic       arb_en    = 1'b0;
    arb_state_e state_dbg;

    ipsl_pcie_cfg_arb_if bus ();

    ipsl_pcie_cfg_arb #(.TIMEOUT_CYCLES(TO), .TAG_INIT(TAG0)) dut (
        .pclk_div2   (pclk_div2),
        .apb_rst_n   (apb_rst_n),
        .arb_en      (arb_en),
        .bus         (bus),
        .state_dbg_o (state_dbg)
    );

    // ---------------- clock / cycle count ----------------
    always #5 pclk_div2 = ~pclk_div2;

    int cyc = 0;
    always @(posedge pclk_div2) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;

    logic [TX_W-1:0]  tx_q[$];     // {cycle, tag, fields}
    logic [RSP_W-1:0] rsp_q[$];    // {cycle, onehot, status, rdata, timeout}
    logic [33:0]      rdy_q[$];    // {cycle, onehot}
    logic [31:0]      stray_q[$];  // cycle

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model state ----------------
    cfg_req_t    f_req[2];
    logic [1:0]  pend = 2'b00;
    int          m_busy_until = -1;
    int          m_tx_cyc = -1;
    int          m_cpl_cyc = -1;
    int          m_last = 1;
    logic [7:0]  m_tag = TAG0;
    logic [2:0]  m_cpl_status;
    logic [31:0] m_cpl_data;
    int          n_grants = 0;

    int          req_pct = 0;
    int          stray_pct = 0;
    bit          force_stray = 1'b0;
    int          plan_k = -2;
    logic [2:0]  plan_status;
    logic [31:0] plan_data;

    task automatic new_req(input int i);
        f_req[i] = cfg_req_t'({$urandom(), $urandom()});
        pend[i]  = 1'b1;
    endtask

    task automatic set_req(input int i, input cfg_req_t r);
        f_req[i] = r;
        pend[i]  = 1'b1;
    endtask

    task automatic plan(input int k, input logic [2:0] st, input logic [31:0] d);
        plan_k      = k;
        plan_status = st;
        plan_data   = d;
    endtask

    // One clock cycle: drive inputs, predict what this cycle causes, advance.
    task automatic step();
        int g;
        int k;
        int rsp_cyc;
        logic [1:0] oh;
        for (int i = 0; i < 2; i++) begin
            if (!pend[i] && req_pct > 0 && $urandom_range(1, 100) <= req_pct) new_req(i);
        end
        bus.req_valid = pend;
        for (int i = 0; i < 2; i++) begin
            bus.req_fmt[i]              = f_req[i].fmt;
            bus.req_type[i]             = f_req[i].typ;
            bus.req_fbe[4*i +: 4]       = f_req[i].fbe;
            bus.req_des_id[16*i +: 16]  = f_req[i].des_id;
            bus.req_reg_num[10*i +: 10] = f_req[i].reg_num;
            bus.req_wdata[32*i +: 32]   = f_req[i].wdata;
        end

        bus.pcie_cfg_cpl_rcv    = 1'b0;
        bus.pcie_cfg_cpl_status = 3'($urandom());
        bus.pcie_cfg_rx_data    = $urandom();
        if (cyc == m_cpl_cyc) begin
            bus.pcie_cfg_cpl_rcv    = 1'b1;
            bus.pcie_cfg_cpl_status = m_cpl_status;
            bus.pcie_cfg_rx_data    = m_cpl_data;
        end else if (apb_rst_n && !(cyc > m_tx_cyc && cyc < m_busy_until) &&
                     (force_stray || (stray_pct > 0 && $urandom_range(1, 100) <= stray_pct))) begin
            bus.pcie_cfg_cpl_rcv = 1'b1;
            stray_q.push_back(32'(cyc + 1));
            force_stray = 1'b0;
        end

        if (!apb_rst_n) begin
            // Everything still scheduled after this edge is abandoned.
            for (int i = tx_q.size() - 1; i >= 0; i--)    if (tx_q[i][103:72] > cyc) tx_q.delete(i);
            for (int i = rsp_q.size() - 1; i >= 0; i--)   if (rsp_q[i][69:38] > cyc) rsp_q.delete(i);
            for (int i = rdy_q.size() - 1; i >= 0; i--)   if (rdy_q[i][33:2] > cyc)  rdy_q.delete(i);
            for (int i = stray_q.size() - 1; i >= 0; i--) if (stray_q[i] > cyc)      stray_q.delete(i);
            m_busy_until = cyc;
            m_cpl_cyc    = -1;
            m_tag        = TAG0;
            m_last       = 1;
        end else if (arb_en && cyc > m_busy_until && pend != 2'b00) begin
            if (pend == 2'b11) g = (m_last == 0) ? 1 : 0;
            else               g = pend[1] ? 1 : 0;
            oh = (g == 1) ? 2'b10 : 2'b01;
            rdy_q.push_back({32'(cyc), oh});
            tx_q.push_back({32'(cyc + 1), m_tag, f_req[g]});
            m_tag    = m_tag + 8'd1;
            m_last   = g;
            m_tx_cyc = cyc + 1;
            if (plan_k != -2) begin
                k = plan_k; m_cpl_status = plan_status; m_cpl_data = plan_data; plan_k = -2;
            end else begin
                case ($urandom_range(0, 7))
                    0:       k = -1;
                    1:       k = int'(TO);
                    default: k = $urandom_range(1, int'(TO) - 1);
                endcase
                m_cpl_status = 3'($urandom());
                m_cpl_data   = $urandom();
            end
            if (k < 0) begin
                m_cpl_cyc = -1;
                rsp_cyc   = m_tx_cyc + int'(TO) + 1;
                rsp_q.push_back({32'(rsp_cyc), oh, 3'b000, 32'h0, 1'b1});
            end else begin
                m_cpl_cyc = m_tx_cyc + k;
                rsp_cyc   = m_tx_cyc + k + 1;
                rsp_q.push_back({32'(rsp_cyc), oh, m_cpl_status, m_cpl_data, 1'b0});
            end
            m_busy_until = rsp_cyc;
            pend[g]      = 1'b0;
            n_grants++;
        end
        @(posedge pclk_div2);
        #1;
    endtask

    task automatic do_reset(input int n);
        apb_rst_n = 1'b0;
        repeat (n) step();
        apb_rst_n = 1'b1;
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max; i++) begin
            if (pend == 2'b00 && cyc > m_busy_until) break;
            step();
        end
        chk("drain_budget", (pend == 2'b00 && cyc > m_busy_until), 1'b1);
    endtask

    task automatic check_reset_vals();
        chk("rst_tx_en",     bus.tx_en, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
        chk("rst_timeout",   bus.rsp_timeout, 1'b0);
        chk("rst_tag",       bus.pcie_cfg_tag, TAG0);
        chk("rst_tlp",       {bus.pcie_cfg_fmt, bus.pcie_cfg_type, bus.pcie_cfg_fbe, bus.pcie_cfg_des_id,
                              bus.pcie_cfg_reg_num, bus.pcie_cfg_tx_data}, 64'h0);
        chk("rst_rsp_data",  {bus.rsp_status, bus.rsp_rdata}, 35'h0);
        chk("rst_state",     state_dbg, ST_IDLE);
    endtask

    // ---------------- monitor ----------------
    logic [TX_W-1:0]  mon_tx;
    logic [RSP_W-1:0] mon_rsp;
    logic [33:0]      mon_rdy;
    logic [31:0]      mon_st;
    logic [63:0]      last_tlp = '0;
    logic [63:0]      dut_tlp;

    assign dut_tlp = {bus.pcie_cfg_fmt, bus.pcie_cfg_type, bus.pcie_cfg_fbe, bus.pcie_cfg_des_id,
                      bus.pcie_cfg_reg_num, bus.pcie_cfg_tx_data};

    always @(negedge pclk_div2) begin
        if (bus.req_ready != 2'b00) begin
            if (rdy_q.size() == 0) chk("ready_unexpected", bus.req_ready, 2'b00);
            else begin
                mon_rdy = rdy_q.pop_front();
                chk("ready_cycle", cyc, mon_rdy[33:2]);
                chk("ready_grant", bus.req_ready, mon_rdy[1:0]);
            end
        end else if (rdy_q.size() != 0 && rdy_q[0][33:2] <= cyc) begin
            mon_rdy = rdy_q.pop_front();
            chk("ready_missing", bus.req_ready, mon_rdy[1:0]);
        end

        if (bus.tx_en) begin
            if (tx_q.size() == 0) chk("tx_en_unexpected", 1'b1, 1'b0);
            else begin
                mon_tx = tx_q.pop_front();
                chk("tx_cycle", cyc, mon_tx[103:72]);
                chk("tx_tag", bus.pcie_cfg_tag, mon_tx[71:64]);
                chk("tx_fields", dut_tlp, mon_tx[63:0]);
                last_tlp = mon_tx[63:0];
            end
        end else if (tx_q.size() != 0 && tx_q[0][103:72] <= cyc) begin
            void'(tx_q.pop_front());
            chk("tx_en_missing", 1'b0, 1'b1);
        end

        if (bus.rsp_valid != 2'b00) begin
            if (rsp_q.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 2'b00);
            else begin
                mon_rsp = rsp_q.pop_front();
                chk("rsp_cycle", cyc, mon_rsp[69:38]);
                chk("rsp_payload", {bus.rsp_valid, bus.rsp_status, bus.rsp_rdata, bus.rsp_timeout},
                    mon_rsp[37:0]);
                chk("tlp_hold", dut_tlp, last_tlp);
            end
        end else begin
            if (bus.rsp_timeout) chk("timeout_without_valid", bus.rsp_timeout, 1'b0);
            if (rsp_q.size() != 0 && rsp_q[0][69:38] <= cyc) begin
                void'(rsp_q.pop_front());
                chk("rsp_missing", 1'b0, 1'b1);
            end
        end

        if (bus.stray_cpl) begin
            if (stray_q.size() == 0) chk("stray_unexpected", 1'b1, 1'b0);
            else begin
                mon_st = stray_q.pop_front();
                chk("stray_cycle", cyc, mon_st);
            end
        end else if (stray_q.size() != 0 && stray_q[0] <= cyc) begin
            void'(stray_q.pop_front());
            chk("stray_missing", 1'b0, 1'b1);
        end
    end

    // ---------------- stimulus ----------------
    int target;

    initial begin
        bus.req_valid = '0;   bus.req_fmt = '0;     bus.req_type = '0;  bus.req_fbe = '0;
        bus.req_des_id = '0;  bus.req_reg_num = '0; bus.req_wdata = '0;
        bus.pcie_cfg_cpl_rcv = 1'b0; bus.pcie_cfg_cpl_status = '0; bus.pcie_cfg_rx_data = '0;
        f_req[0] = '0;
        f_req[1] = '0;
        @(posedge pclk_div2);
        #1;
        do_reset(3);
        check_reset_vals();

        // Single read, completion five cycles after launch.
        arb_en = 1'b1;
        set_req(0, '{fmt: 1'b0, typ: 1'b0, fbe: 4'hF, des_id: 16'h0100, reg_num: 10'h004, wdata: 32'h0});
        plan(5, 3'b000, 32'h1234_5678);
        drain(100);

        // Both requesters continuously valid from reset: alternation 0,1,0,1.
        do_reset(2);
        check_reset_vals();
        target  = n_grants + 4;
        req_pct = 100;
        new_req(0);
        new_req(1);
        for (int i = 0; i < 400 && n_grants < target; i++) step();
        req_pct = 0;
        drain(200);

        // Timeout, then a normal request.
        plan(-1, 3'b000, 32'h0);
        new_req(1);
        drain(100);
        new_req(0);
        drain(100);

        // Completion on the expiry cycle, then a stray completion in IDLE.
        plan(int'(TO), 3'b001, 32'hCAFE_F00D);
        new_req(0);
        drain(100);
        force_stray = 1'b1;
        step();
        step();
        step();

        // Reset while waiting, then a late completion.
        plan(-1, 3'b000, 32'h0);
        new_req(1);
        repeat (6) step();
        do_reset(2);
        check_reset_vals();
        force_stray = 1'b1;
        repeat (3) step();

        // Grants withheld while disabled; requester 0 wins once enabled.
        arb_en = 1'b0;
        new_req(0);
        new_req(1);
        repeat (100) step();
        arb_en = 1'b1;
        step();

        // Random traffic long enough for the tag to wrap.
        req_pct   = 40;
        stray_pct = 5;
        target    = n_grants + 300;
        for (int i = 0; i < 30000 && n_grants < target; i++) begin
            arb_en = ($urandom_range(0, 7) != 0);
            step();
        end
        chk("grant_budget", (n_grants >= target), 1'b1);
        req_pct   = 0;
        stray_pct = 0;
        arb_en    = 1'b1;
        drain(500);
        repeat (3) step();
        chk("queues_empty", tx_q.size() + rsp_q.size() + rdy_q.size() + stray_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
